// File: rtl/cache_pmem_arbiter_if.sv
// rtl/cache_pmem_arbiter_if.sv - line-granular pmem request/response bus
interface cache_pmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    // master issues the request (cache side of a link), slave answers it
    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/cache_pmem_arbiter.sv
// rtl/cache_pmem_arbiter.sv - round-robin merge of icache/dcache pmem traffic onto one memory port
module cache_pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_pmem_arbiter_if.slave  i_pmem,
    cache_pmem_arbiter_if.slave  d_pmem,
    cache_pmem_arbiter_if.master pmem,
    output logic [CNT_W-1:0]     i_txn_count,
    output logic [CNT_W-1:0]     d_txn_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_d;      // 1 when the dcache held the most recent grant
    logic              r_op_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_i_cnt;
    logic [CNT_W-1:0]  r_d_cnt;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_done_i;
    logic              w_done_d;
    logic              w_pmem_read;
    logic              w_pmem_write;
    logic              w_i_resp;
    logic              w_d_resp;
    logic [LINE_W-1:0] w_i_rdata;
    logic [LINE_W-1:0] w_d_rdata;

    // state register; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // arbitration, next state and all bus outputs
    always_comb begin
        w_next_state = r_state;
        w_req_i      = i_pmem.read | i_pmem.write;
        w_req_d      = d_pmem.read | d_pmem.write;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done_i     = 1'b0;
        w_done_d     = 1'b0;
        w_pmem_read  = 1'b0;
        w_pmem_write = 1'b0;
        w_i_resp     = 1'b0;
        w_d_resp     = 1'b0;
        w_i_rdata    = '0;
        w_d_rdata    = '0;
        case (r_state)
            IDLE: begin
                // on a tie the client that did not win last time goes first
                if (w_req_d && (!w_req_i || !r_last_d)) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end else if (w_req_i) begin
                    w_grant_i    = 1'b1;
                    w_next_state = BUSY_I;
                end
            end
            BUSY_I: begin
                w_pmem_read  = ~r_op_write;
                w_pmem_write = r_op_write;
                w_i_rdata    = pmem.rdata;
                w_i_resp     = pmem.resp;
                if (pmem.resp) begin
                    w_done_i     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            BUSY_D: begin
                w_pmem_read  = ~r_op_write;
                w_pmem_write = r_op_write;
                w_d_rdata    = pmem.rdata;
                w_d_resp     = pmem.resp;
                if (pmem.resp) begin
                    w_done_d     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // capture the granted request so memory sees it stable whatever the client does next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d   <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_grant_d) begin
            r_last_d   <= 1'b1;
            r_op_write <= d_pmem.write;
            r_addr     <= d_pmem.address;
            r_wdata    <= d_pmem.wdata;
        end else if (w_grant_i) begin
            r_last_d   <= 1'b0;
            r_op_write <= i_pmem.write;
            r_addr     <= i_pmem.address;
            r_wdata    <= i_pmem.wdata;
        end
    end

    // saturating per-client completion counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_cnt <= '0;
            r_d_cnt <= '0;
        end else begin
            if (w_done_i && (r_i_cnt != '1)) begin
                r_i_cnt <= r_i_cnt + CNT_W'(1);
            end
            if (w_done_d && (r_d_cnt != '1)) begin
                r_d_cnt <= r_d_cnt + CNT_W'(1);
            end
        end
    end

    assign pmem.read    = w_pmem_read;
    assign pmem.write   = w_pmem_write;
    assign pmem.address = r_addr;
    assign pmem.wdata   = r_wdata;

    assign i_pmem.rdata = w_i_rdata;
    assign i_pmem.resp  = w_i_resp;
    assign d_pmem.rdata = w_d_rdata;
    assign d_pmem.resp  = w_d_resp;

    assign i_txn_count  = r_i_cnt;
    assign d_txn_count  = r_d_cnt;

endmodule
